// File: rtl/dcnn_ctrl_pkg.sv
// Shared phase encoding and watchdog defaults for the DCNN load/run controller.
// The phase_t values are visible on the controller's phase output.
package dcnn_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_LOAD_CNN = 3'd1,
    PH_LOAD_FC  = 3'd2,
    PH_LOAD_IMG = 3'd3,
    PH_RUN      = 3'd4,
    PH_ERROR    = 3'd5
  } phase_t;

  localparam int TIMEOUT_W_DEF   = 20;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  function automatic logic phase_is_busy(input phase_t p);
    return (p == PH_LOAD_CNN) || (p == PH_LOAD_FC) ||
           (p == PH_LOAD_IMG) || (p == PH_RUN);
  endfunction

  // First phase of a pass: anything not resident is reloaded, and an ERROR
  // recovery never trusts the resident flags.
  function automatic phase_t start_target(input logic reload,
                                          input logic cnn_loaded,
                                          input logic fc_loaded,
                                          input logic from_error);
    if (reload || !cnn_loaded || from_error) return PH_LOAD_CNN;
    if (!fc_loaded) return PH_LOAD_FC;
    return PH_LOAD_IMG;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input: rise is high in the cycle where d is 1
// and was 0 at the previous clock edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/load_sequencer.sv
// Load/run controller: CNN weights -> FC weights -> image -> accelerator run,
// skipping resident weights. Optional per-phase watchdog under LOAD_TIMEOUT_EN.
module load_sequencer
  import dcnn_ctrl_pkg::*;
`ifdef LOAD_TIMEOUT_EN
#(
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       reload_weights,
  output logic       loadCNN,
  output logic       loadFC,
  output logic       loadImg,
  input  logic       finishCNN,
  input  logic       finishFC,
  input  logic       done,
  output logic       accel_start,
  input  logic       accel_done,
  output logic       busy,
  output logic       result_valid,
  output logic [2:0] phase,
  output logic       error
);

  // Loader handshake: load* is a level held for the whole phase; the loader
  // answers with a rising finish*/done level, counted only in the matching
  // phase, and drops it some time after load* has fallen.
  phase_t state_q, state_d;
  logic   cnn_loaded_q, cnn_loaded_d;
  logic   fc_loaded_q, fc_loaded_d;
  logic   load_cnn_q, load_cnn_d;
  logic   load_fc_q, load_fc_d;
  logic   load_img_q, load_img_d;
  logic   accel_start_q, accel_start_d;
  logic   busy_q, busy_d;
  logic   result_valid_q, result_valid_d;
  logic   cnn_rise, fc_rise, img_rise;
  logic   timeout;

`ifdef LOAD_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 error_q, error_d;
`endif

  rise_detect u_rise_cnn (.clk(clk), .rst_n(rst_n), .d(finishCNN), .rise(cnn_rise));
  rise_detect u_rise_fc  (.clk(clk), .rst_n(rst_n), .d(finishFC),  .rise(fc_rise));
  rise_detect u_rise_img (.clk(clk), .rst_n(rst_n), .d(done),      .rise(img_rise));

  always_comb begin
    state_d      = state_q;
    cnn_loaded_d = cnn_loaded_q;
    fc_loaded_d  = fc_loaded_q;
`ifdef LOAD_TIMEOUT_EN
    timeout = (wdog_q == WDOG_LAST);
`else
    timeout = 1'b0;
`endif

    // Completion edges are tested before the watchdog so an edge landing on
    // the expiry cycle still advances the sequence.
    case (state_q)
      PH_IDLE, PH_ERROR: begin
        if (start) begin
          state_d = start_target(reload_weights, cnn_loaded_q, fc_loaded_q,
                                 state_q == PH_ERROR);
        end
      end
      PH_LOAD_CNN: begin
        if (cnn_rise) begin
          cnn_loaded_d = 1'b1;
          state_d      = fc_loaded_q ? PH_LOAD_IMG : PH_LOAD_FC;
        end else if (timeout) begin
          state_d = PH_ERROR;
        end
      end
      PH_LOAD_FC: begin
        if (fc_rise) begin
          fc_loaded_d = 1'b1;
          state_d     = PH_LOAD_IMG;
        end else if (timeout) begin
          state_d = PH_ERROR;
        end
      end
      PH_LOAD_IMG: begin
        if (img_rise)     state_d = PH_RUN;
        else if (timeout) state_d = PH_ERROR;
      end
      PH_RUN: begin
        // accel_start_q marks the RUN entry cycle; accel_done is ignored there.
        if (accel_done && !accel_start_q) state_d = PH_IDLE;
        else if (timeout)                 state_d = PH_ERROR;
      end
      default: state_d = PH_IDLE;
    endcase

    // FC weights depend on the CNN load, so a CNN reload invalidates both.
    if (state_d == PH_LOAD_CNN && state_q != PH_LOAD_CNN) begin
      cnn_loaded_d = 1'b0;
      fc_loaded_d  = 1'b0;
    end

    load_cnn_d     = (state_d == PH_LOAD_CNN);
    load_fc_d      = (state_d == PH_LOAD_FC);
    load_img_d     = (state_d == PH_LOAD_IMG);
    busy_d         = phase_is_busy(state_d);
    accel_start_d  = (state_d == PH_RUN) && (state_q != PH_RUN);
    result_valid_d = (state_q == PH_RUN) && (state_d == PH_IDLE);

`ifdef LOAD_TIMEOUT_EN
    error_d = (state_d == PH_ERROR);
    if (state_d != state_q)          wdog_d = '0;
    else if (phase_is_busy(state_q)) wdog_d = wdog_q + WDOG_ONE;
    else                             wdog_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PH_IDLE;
      cnn_loaded_q   <= 1'b0;
      fc_loaded_q    <= 1'b0;
      load_cnn_q     <= 1'b0;
      load_fc_q      <= 1'b0;
      load_img_q     <= 1'b0;
      accel_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      wdog_q         <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnn_loaded_q   <= cnn_loaded_d;
      fc_loaded_q    <= fc_loaded_d;
      load_cnn_q     <= load_cnn_d;
      load_fc_q      <= load_fc_d;
      load_img_q     <= load_img_d;
      accel_start_q  <= accel_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
`ifdef LOAD_TIMEOUT_EN
      wdog_q         <= wdog_d;
      error_q        <= error_d;
`endif
    end
  end

  assign loadCNN      = load_cnn_q;
  assign loadFC       = load_fc_q;
  assign loadImg      = load_img_q;
  assign accel_start  = accel_start_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign phase        = state_q;
`ifdef LOAD_TIMEOUT_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer: randomized loader/accelerator timing
// against a pass-level model of the resident weight flags and phase order.
module tb_load_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, reload_weights;
  logic       finishCNN, finishFC, done, accel_done;
  logic       loadCNN, loadFC, loadImg, accel_start, busy, result_valid, error;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference model state: which weights the loader currently holds.
  bit cnn_res = 1'b0;
  bit fc_res  = 1'b0;
  bit err_state = 1'b0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef LOAD_TIMEOUT_EN
  load_sequencer #(.TIMEOUT_W(20), .TIMEOUT_CYC(16)) dut (
`else
  load_sequencer dut (
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .reload_weights(reload_weights),
    .loadCNN(loadCNN), .loadFC(loadFC), .loadImg(loadImg),
    .finishCNN(finishCNN), .finishFC(finishFC), .done(done),
    .accel_start(accel_start), .accel_done(accel_done), .busy(busy),
    .result_valid(result_valid), .phase(phase), .error(error)
  );

  // Output picture implied by a phase: one load line per load phase, busy in 1..4.
  function automatic logic [9:0] exp_vec(input logic [2:0] p, input logic astart,
                                         input logic rvalid, input logic err);
    return {p, p == 3'd1, p == 3'd2, p == 3'd3, (p >= 3'd1 && p <= 3'd4),
            astart, rvalid, err};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 1'b0; reload_weights = 1'b0;
    finishCNN = 1'b0; finishFC = 1'b0; done = 1'b0; accel_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    cnn_res = 1'b0; fc_res = 1'b0; err_state = 1'b0;
  endtask

  // One full pass driven like a loader; checks every cycle at the negedge.
  task automatic run_pass(input bit reload, input bit noise, input int cnn_delay,
                          input bit abort_in_run, input string name);
    logic [2:0] p;
    logic [9:0] got, want;
    int d, w, acc;
    exp_q.delete();
    if (reload || !cnn_res || err_state) begin
      exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    end else if (!fc_res) begin
      exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    end else begin
      exp_q.push_back(3'd3);
    end
    start = 1'b1; reload_weights = reload;
    tick();
    start = 1'b0; reload_weights = 1'($urandom_range(0, 1));
    err_state = 1'b0;
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      if (p == 3'd1) begin
        cnn_res = 1'b0; fc_res = 1'b0;
      end
      d = (p == 3'd1 && cnn_delay >= 0) ? cnn_delay : $urandom_range(0, 5);
      if (noise && p == 3'd2 && d < 3) d = 3;
      for (int i = 0; i < d + 1; i++) begin
        got  = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
        want = exp_vec(p, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s phase%0d cyc%0d: got %b expected %b", name, p, i, got, want);
        end
        if (i < d) begin
          if (noise && p == 3'd2 && i == 0) begin
            start = 1'b1; reload_weights = 1'($urandom_range(0, 1)); finishCNN = 1'b0;
          end else if (noise && p == 3'd2 && i == 1) begin
            start = 1'b0; finishCNN = 1'b1;
          end
          tick();
        end
      end
      case (p)
        3'd1: finishCNN = 1'b1;
        3'd2: finishFC  = 1'b1;
        default: done   = 1'b1;
      endcase
      tick();
      if (p == 3'd1) cnn_res = 1'b1;
      if (p == 3'd2) fc_res  = 1'b1;
    end
    if (abort_in_run) begin
      got  = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
      want = exp_vec(3'd4, 1'b1, 1'b0, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s run_entry: got %b expected %b", name, got, want);
      end
      return;
    end
    w = $urandom_range(0, 4);
    acc = (w < 1) ? 1 : w;
    for (int i = 0; i <= acc; i++) begin
      got  = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
      want = exp_vec(3'd4, i == 0, 1'b0, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s run cyc%0d (done at %0d): got %b expected %b", name, i, w, got, want);
      end
      if (i == w) accel_done = 1'b1;
      tick();
    end
    got  = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
    want = exp_vec(3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s result: got %b expected %b", name, got, want);
    end
    clear_inputs();
    tick();
    got  = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
    want = exp_vec(3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s idle_after: got %b expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    got = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", got, 10'd0);
    end
    rst_n = 1'b1;
    tick(); tick();
    got = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", got, 10'd0);
    end
    cnn_res = 1'b0; fc_res = 1'b0; err_state = 1'b0;
  endtask

  task automatic test_cold_start();
    run_pass(1'b0, 1'b0, -1, 1'b0, "cold_start");
  endtask

  task automatic test_skip_weights();
    run_pass(1'b0, 1'b0, -1, 1'b0, "skip_weights");
  endtask

  task automatic test_reload();
    run_pass(1'b1, 1'b0, -1, 1'b0, "reload");
    run_pass(1'b0, 1'b0, -1, 1'b0, "after_reload");
  endtask

  task automatic test_ignore_start();
    run_pass(1'b1, 1'b1, -1, 1'b0, "ignore_start");
  endtask

  task automatic test_random_passes();
    for (int k = 0; k < 8; k++) begin
      run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0,
               $sformatf("random%0d", k));
    end
  endtask

  task automatic test_reset_in_run();
    logic [9:0] got;
    run_pass(1'b1, 1'b0, -1, 1'b1, "reset_in_run");
    #2;
    rst_n = 1'b0;
    #1;
    got = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_in_run: got %b expected %b", got, 10'd0);
    end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    cnn_res = 1'b0; fc_res = 1'b0; err_state = 1'b0;
    run_pass(1'b0, 1'b0, -1, 1'b0, "after_reset_reload");
  endtask

`ifdef LOAD_TIMEOUT_EN
  task automatic test_watchdog();
    logic [9:0] got, want;
    do_reset();
    start = 1'b1; reload_weights = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      got  = {phase, loadCNN, loadFC, loadImg, busy, accel_start, result_valid, error};
      want = (i < 16) ? exp_vec(3'd1, 1'b0, 1'b0, 1'b0) : exp_vec(3'd5, 1'b0, 1'b0, 1'b1);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL watchdog cyc%0d: got %b expected %b", i, got, want);
      end
      if (i < 16) tick();
    end
    err_state = 1'b1; cnn_res = 1'b0; fc_res = 1'b0;
    // Completion edge presented on the expiry cycle must win.
    run_pass(1'b0, 1'b0, 15, 1'b0, "edge_wins");
  endtask
`else
  task automatic test_no_watchdog();
    do_reset();
    run_pass(1'b0, 1'b0, 40, 1'b0, "no_watchdog");
  endtask
`endif

  initial begin
    test_reset();
    test_cold_start();
    test_skip_weights();
    test_reload();
    test_ignore_start();
    test_random_passes();
    test_reset_in_run();
`ifdef LOAD_TIMEOUT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
